// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one imem request at a time,
// and hands fetched words to decode, with redirect/exception squashing.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcplus4,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_valid,
  output logic [31:0] pc
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t      state, state_next;
  logic [31:0] pc_next;
  logic [31:0] redirect_pc;
  logic        redirect_any;
  logic        capture;
  logic        drop_valid;
  logic        unused_target_bits;

  assign unused_target_bits = ^redirect_target[1:0];

  // Exception outranks a branch/jump when both arrive together.
  assign redirect_any = exc_valid | redirect_valid;
  assign redirect_pc  = exc_valid ? EXC_VECTOR : {redirect_target[31:2], 2'b00};

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    drop_valid = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (redirect_any) pc_next = redirect_pc;
        if (imem_gnt) state_next = redirect_any ? DRAIN : WAIT;
      end
      WAIT: begin
        if (redirect_any) begin
          pc_next    = redirect_pc;
          state_next = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          capture    = 1'b1;
          pc_next    = pc + 32'd4;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (redirect_any) begin
          pc_next    = redirect_pc;
          drop_valid = 1'b1;
          state_next = REQ;
        end else if (id_ready) begin
          drop_valid = 1'b1;
          state_next = REQ;
        end
      end
      DRAIN: begin
        // The stale response still has to be absorbed before a new request.
        if (redirect_any) pc_next = redirect_pc;
        if (imem_rvalid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid   <= 1'b0;
      if_instr   <= 32'd0;
      if_pc      <= 32'd0;
      if_pcplus4 <= 32'd0;
    end else if (capture) begin
      if_valid   <= 1'b1;
      if_instr   <= imem_rdata;
      if_pc      <= pc;
      if_pcplus4 <= pc + 32'd4;
    end else if (drop_valid) begin
      if_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, corner-case
// sequences and a random phase checked against a transaction-level model.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h8000_0180;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pcplus4;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic [31:0] pc;

  int tests = 0;
  int fails = 0;

  fetch_sequencer #(.RESET_VECTOR(RESET_VECTOR), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pcplus4(if_pcplus4),
    .id_ready(id_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .exc_valid(exc_valid), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: outstanding-request count, stale flag, held word.
  bit          m_idle;
  logic [31:0] m_pc;
  int          m_out;
  bit          m_stale;
  bit          m_held;
  logic [31:0] m_ipc, m_ipp4, m_instr;

  typedef struct {
    bit          g, rv, rdy, rd, ex;
    logic [31:0] tgt, data;
    bit          e_req, e_valid;
    logic [31:0] e_pc, e_ifpc, e_instr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_idle = 1; m_pc = RESET_VECTOR; m_out = 0; m_stale = 0;
    m_held = 0; m_ipc = 0; m_ipp4 = 0; m_instr = 0;
  endtask

  task automatic modelStep(input bit g, input bit rv, input bit rdy, input bit rd,
                           input bit ex, input logic [31:0] tgt, input logic [31:0] data);
    bit          redir;
    bit          was_held;
    bit          req;
    logic [31:0] new_pc;
    redir  = ex | rd;
    new_pc = ex ? EXC_VECTOR : {tgt[31:2], 2'b00};
    if (m_idle) begin
      m_idle = 0;
    end else begin
      was_held = m_held;
      req      = !m_held && (m_out == 0);
      if (m_out == 1 && rv) begin
        m_out = 0;
        if (!m_stale && !redir) begin
          m_held = 1; m_ipc = m_pc; m_ipp4 = m_pc + 32'd4; m_instr = data;
          m_pc = m_pc + 32'd4;
        end
      end else if (req && g) begin
        m_out = 1; m_stale = redir;
      end
      if (was_held && (rdy || redir)) m_held = 0;
      if (redir) begin
        m_pc = new_pc;
        if (m_out == 1) m_stale = 1;
      end
    end
  endtask

  task automatic checkOutput();
    bit exp_req;
    exp_req = !m_idle && !m_held && (m_out == 0);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("if_valid", if_valid, m_held);
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_ipc);
    chk("if_pcplus4", if_pcplus4, m_ipp4);
  endtask

  // Inputs are driven at the falling edge, results sampled at the next falling edge.
  task automatic applyStimulus(input bit g, input bit rv, input bit rdy, input bit rd,
                               input bit ex, input logic [31:0] tgt, input logic [31:0] data);
    imem_gnt = g; imem_rvalid = rv; id_ready = rdy; redirect_valid = rd;
    exc_valid = ex; redirect_target = tgt; imem_rdata = data;
    modelStep(g, rv, rdy, rd, ex, tgt, data);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic clearInputs();
    imem_gnt = 0; imem_rvalid = 0; id_ready = 0; redirect_valid = 0;
    exc_valid = 0; redirect_target = 0; imem_rdata = 0;
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Zero-wait sequential fetch of 0,4,8 then redirect while waiting on rvalid.
    vecs[0]  = '{1,1,1,0,0, 32'h0, 32'hBAD0_0000, 1,0, 32'h0,   32'h0, 32'h0};
    vecs[1]  = '{1,1,1,0,0, 32'h0, 32'hBAD0_0001, 0,0, 32'h0,   32'h0, 32'h0};
    vecs[2]  = '{1,1,1,0,0, 32'h0, 32'h1111_0000, 0,1, 32'h4,   32'h0, 32'h1111_0000};
    vecs[3]  = '{1,1,1,0,0, 32'h0, 32'hBAD0_0003, 1,0, 32'h4,   32'h0, 32'h1111_0000};
    vecs[4]  = '{1,1,1,0,0, 32'h0, 32'hBAD0_0004, 0,0, 32'h4,   32'h0, 32'h1111_0000};
    vecs[5]  = '{1,1,1,0,0, 32'h0, 32'h1111_0004, 0,1, 32'h8,   32'h4, 32'h1111_0004};
    vecs[6]  = '{1,1,1,0,0, 32'h0, 32'hBAD0_0006, 1,0, 32'h8,   32'h4, 32'h1111_0004};
    vecs[7]  = '{1,1,1,0,0, 32'h0, 32'hBAD0_0007, 0,0, 32'h8,   32'h4, 32'h1111_0004};
    vecs[8]  = '{1,1,1,0,0, 32'h0, 32'h1111_0008, 0,1, 32'hC,   32'h8, 32'h1111_0008};
    vecs[9]  = '{1,0,1,0,0, 32'h0, 32'h0,         1,0, 32'hC,   32'h8, 32'h1111_0008};
    vecs[10] = '{1,0,1,0,0, 32'h0, 32'h0,         0,0, 32'hC,   32'h8, 32'h1111_0008};
    vecs[11] = '{0,0,1,1,0, 32'h0000_0403, 32'h0, 0,0, 32'h400, 32'h8, 32'h1111_0008};
    vecs[12] = '{0,0,1,0,0, 32'h0, 32'h0,         0,0, 32'h400, 32'h8, 32'h1111_0008};
    vecs[13] = '{0,1,1,0,0, 32'h0, 32'hDEAD_BEEF, 1,0, 32'h400, 32'h8, 32'h1111_0008};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].g, vecs[i].rv, vecs[i].rdy, vecs[i].rd, vecs[i].ex,
                    vecs[i].tgt, vecs[i].data);
      chk($sformatf("vec%0d req", i), imem_req, vecs[i].e_req);
      if (vecs[i].e_req) chk($sformatf("vec%0d addr", i), imem_addr, vecs[i].e_pc);
      chk($sformatf("vec%0d if_valid", i), if_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d pc", i), pc, vecs[i].e_pc);
      chk($sformatf("vec%0d if_pc", i), if_pc, vecs[i].e_ifpc);
      chk($sformatf("vec%0d if_instr", i), if_instr, vecs[i].e_instr);
    end

    // Decode stall: held word must stay put with no new request.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h2008_0005);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 32'h5555_5555);
      chk("stall if_valid", if_valid, 1'b1);
      chk("stall if_instr", if_instr, 32'h2008_0005);
      chk("stall if_pc", if_pc, 32'h400);
      chk("stall imem_req", imem_req, 1'b0);
    end
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    chk("stall release req", imem_req, 1'b1);
    chk("stall release addr", imem_addr, 32'h404);

    // Exception and redirect together in HOLD with id_ready high.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h0BAD_F00D);
    applyStimulus(0, 0, 1, 1, 1, 32'h0000_1234, 0);
    chk("exc if_valid", if_valid, 1'b0);
    chk("exc req", imem_req, 1'b1);
    chk("exc addr", imem_addr, EXC_VECTOR);

    // Abandoned request then a fetch at the top of the address space.
    applyStimulus(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0);
    chk("abandon addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h0000_0013);
    chk("wrap if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap if_pcplus4", if_pcplus4, 32'h0);
    chk("wrap pc", pc, 32'h0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    chk("wrap addr", imem_addr, 32'h0);

    // Random traffic, including spurious rvalid and redirects in every state.
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, ($urandom % 3) != 0, $urandom_range(0, 1) == 1,
                    ($urandom % 10) == 0, ($urandom % 25) == 0, $urandom, $urandom);
    end

    // Reset arriving while a response is outstanding.
    reset = 1'b1;
    clearInputs();
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    modelReset();
    #1;
    chk("rst if_valid", if_valid, 1'b0);
    chk("rst imem_req", imem_req, 1'b0);
    chk("rst pc", pc, RESET_VECTOR);
    chk("rst if_instr", if_instr, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 1, 0, 0, 0, 0, 32'hDEAD_BEEF);
    chk("post-rst req", imem_req, 1'b1);
    chk("post-rst addr", imem_addr, RESET_VECTOR);
    chk("post-rst if_instr", if_instr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
